// File: rtl/mult_booth_ctrl_if.sv
// ---------------------------------------------------------------------------
// mult_booth_ctrl_if
// Request/response bundle between the main control unit (master) and the
// Booth multiplier controller (slave).
//   start      : single-cycle request from the control unit
//   a_in, b_in : signed multiplicand / multiplier
//   sel        : current Booth select code {Q[0],Q_1}
//   busy       : high while the multiplier iterates
//   done       : one-cycle pulse, hi/lo hold the new product
//   hi, lo     : upper / lower half of the 2*WIDTH product
// WIDTH must match the WIDTH of the mult_booth_ctrl it connects to.
// ---------------------------------------------------------------------------
interface mult_booth_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [1:0]       sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, a_in, b_in,
        input  sel, busy, done, hi, lo
    );

    modport slave (
        input  start, a_in, b_in,
        output sel, busy, done, hi, lo
    );
endinterface

// File: rtl/mult_booth_ctrl.sv
// ---------------------------------------------------------------------------
// mult_booth_ctrl
// Multicycle signed radix-2 Booth multiplier controller (MIPS MULT).
// One Booth step (add/subtract/pass, then arithmetic right shift) per clock
// for WIDTH clocks; the 2*WIDTH product is written to hi/lo together with a
// one-cycle done pulse. Back-to-back requests complete every WIDTH+2 cycles.
//
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of mult_booth_ctrl_if (start, a_in, b_in in;
//             sel, busy, done, hi, lo out)
//
// Parameters:
//   WIDTH   : operand width; product is 2*WIDTH
//   CNT_W   : iteration counter width, 2**CNT_W >= WIDTH
// ---------------------------------------------------------------------------
module mult_booth_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    mult_booth_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;

    // The accumulator carries one extra bit so that -M is exact even for
    // the most negative multiplicand.
    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [CNT_W-1:0] r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [1:0]       w_booth;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_acc_sh;
    logic [WIDTH-1:0] w_q_sh;
    logic             w_last;

    assign w_booth = {r_q[0], r_q1};
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    // Add phase: select 0 / +M / -M / 0, modulo 2**(WIDTH+1).
    always_comb begin
        w_sum = r_acc;
        case (w_booth)
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
    end

    // Shift phase: arithmetic right shift of {acc', Q, Q_1}; Q_1 picks up
    // Q[0] in the sequential block below.
    assign w_acc_sh = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_sh   = {w_sum[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_m     <= {bus.a_in[WIDTH-1], bus.a_in};
                        r_q     <= bus.b_in;
                        r_acc   <= '0;
                        r_q1    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_sh;
                    r_q   <= w_q_sh;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // acc[WIDTH] is only a sign guard; the product is
                        // the low WIDTH acc bits above the shifted Q.
                        r_hi    <= w_acc_sh[WIDTH-1:0];
                        r_lo    <= w_q_sh;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The select code only means something while stepping.
    assign bus.sel  = (r_state == S_RUN) ? w_booth : 2'b00;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_booth_ctrl.sv
module tb_mult_booth_ctrl;

    localparam int W      = 32;
    localparam int PERIOD = 34;
    localparam int N_RAND = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mult_booth_ctrl_if #(.WIDTH(W)) bus ();

    mult_booth_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_v;
    bit          spacing_mode = 0;
    bit          have_prev    = 0;
    int          cyc          = 0;
    int          prev_cyc     = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Exact signed product from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 9))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return W'($urandom());
        endcase
    endfunction

    // Monitor: pops the scoreboard on every done pulse, checks hold/idle rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_hi   = '0;
            last_lo   = '0;
            have_prev = 0;
        end else begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: done=1 at cycle %0d with no request outstanding", cyc);
                end else begin
                    exp_v = sb.pop_front();
                    chk("product", {bus.hi, bus.lo}, exp_v);
                end
                if (spacing_mode && have_prev)
                    chk("done_spacing", 64'(cyc - prev_cyc), 64'(PERIOD));
                have_prev = spacing_mode;
                prev_cyc  = cyc;
                last_hi   = bus.hi;
                last_lo   = bus.lo;
            end else begin
                chk("hilo_hold", {bus.hi, bus.lo}, {last_hi, last_lo});
            end
            if (!bus.busy) chk("sel_idle", 64'(bus.sel), 64'd0);
            chk("busy_and_done", 64'(bus.busy & bus.done), 64'd0);
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.start = 1'b1;
        @(posedge clk);
        sb.push_back(ref_prod(a, b));
        #1 bus.start = 1'b0;
    endtask

    // Counts negedges after the capture edge until done; optionally injects
    // a second start pulse at negedge inj_at.
    task automatic wait_done(input int inj_at, output int edges, output int bn,
                             output logic [1:0] s1, output logic [1:0] s2);
        edges = 0; bn = 0; s1 = 2'b00; s2 = 2'b00;
        do begin
            @(negedge clk);
            edges++;
            if (bus.busy) bn++;
            if (edges == 1) s1 = bus.sel;
            if (edges == 2) s2 = bus.sel;
            if (inj_at != 0 && edges == inj_at) begin
                bus.start = 1'b1; bus.a_in = 2; bus.b_in = 2;
            end
            if (inj_at != 0 && edges == inj_at + 1) bus.start = 1'b0;
        end while (!bus.done && edges < 100);
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", edges);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int         edges, bn;
        logic [1:0] s1, s2;

        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        #12;
        chk("reset_hi",   64'(bus.hi), 64'd0);
        chk("reset_lo",   64'(bus.lo), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_sel",  64'(bus.sel), 64'd0);
        rst_n = 1'b1;

        // 6 x 7
        start_op(32'd6, 32'd7);
        wait_done(0, edges, bn, s1, s2);
        chk("lat_6x7",  64'(edges), 64'd33);
        chk("busy_6x7", 64'(bn), 64'd32);
        chk("hi_6x7",   64'(bus.hi), 64'h0);
        chk("lo_6x7",   64'(bus.lo), 64'h2A);

        // -3 x 5, Booth select sequence
        start_op(32'hFFFF_FFFD, 32'd5);
        wait_done(0, edges, bn, s1, s2);
        chk("sel_step1", 64'(s1), 64'd2);
        chk("sel_step2", 64'(s2), 64'd1);
        chk("hi_m3x5",   64'(bus.hi), 64'hFFFF_FFFF);
        chk("lo_m3x5",   64'(bus.lo), 64'hFFFF_FFF1);

        // most negative operands
        start_op(32'h8000_0000, 32'h8000_0000);
        wait_done(0, edges, bn, s1, s2);
        chk("hi_minxmin", 64'(bus.hi), 64'h4000_0000);
        chk("lo_minxmin", 64'(bus.lo), 64'h0);
        start_op(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, edges, bn, s1, s2);
        chk("hi_minxm1", 64'(bus.hi), 64'h0);
        chk("lo_minxm1", 64'(bus.lo), 64'h8000_0000);

        // zero operand: no early exit
        start_op(32'd0, 32'h1234_5678);
        wait_done(0, edges, bn, s1, s2);
        chk("lat_zero", 64'(edges), 64'd33);

        // start re-pulsed mid-run is ignored
        start_op(32'd6, 32'd7);
        wait_done(10, edges, bn, s1, s2);
        chk("lat_ignore",  64'(edges), 64'd33);
        chk("busy_ignore", 64'(bn), 64'd32);
        chk("lo_ignore",   64'(bus.lo), 64'd42);
        repeat (40) @(negedge clk);
        chk("no_extra_busy", 64'(bus.busy), 64'd0);

        // reset mid-run
        start_op(32'd6, 32'd7);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_hi",   64'(bus.hi), 64'd0);
        chk("rst_lo",   64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_sel",  64'(bus.sel), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        start_op(32'd6, 32'd7);
        wait_done(0, edges, bn, s1, s2);
        chk("lat_after_rst", 64'(edges), 64'd33);
        chk("lo_after_rst",  64'(bus.lo), 64'd42);

        // random back-to-back with start held high; operands keep changing
        spacing_mode = 1;
        @(negedge clk);
        bus.a_in  = rnd_op();
        bus.b_in  = rnd_op();
        bus.start = 1'b1;
        for (int n = 0; n < N_RAND; n++) begin
            @(posedge clk);
            sb.push_back(ref_prod(bus.a_in, bus.b_in));
            if (n == N_RAND - 1) #1 bus.start = 1'b0;
            repeat (PERIOD) begin
                @(negedge clk);
                bus.a_in = rnd_op();
                bus.b_in = rnd_op();
            end
        end
        repeat (40) @(negedge clk);
        spacing_mode = 0;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
